// File: rtl/bias_bank_adder.sv
// rtl/bias_bank_adder.sv - run-time programmable bias banks added to an adder-tree stream
// Operand, result and output registers share one stall enable; each lane saturates independently.
module bias_bank_adder #(
   parameter int N_LANES  = 16,
   parameter int DATA_W   = 18,
   parameter int N_GROUPS = 8,
   parameter int GRP_W    = $clog2(N_GROUPS),
   parameter int LANE_W   = $clog2(N_LANES)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cfg_we,
   input  logic [GRP_W-1:0]          cfg_group,
   input  logic [LANE_W-1:0]         cfg_lane,
   input  logic [DATA_W-1:0]         cfg_data,
   input  logic                      relu_en,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [GRP_W-1:0]          in_group,
   input  logic [N_LANES*DATA_W-1:0] in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [N_LANES*DATA_W-1:0] out_data
);
   localparam int VW = N_LANES * DATA_W;

   logic [DATA_W-1:0] bias_q [N_GROUPS][N_LANES];
   logic [VW-1:0]     sel_bias;
   logic [VW-1:0]     s1_data;
   logic [VW-1:0]     s1_bias;
   logic [VW-1:0]     s2_data;
   logic [VW-1:0]     res;
   logic [DATA_W:0]   sum;
   logic              s1_valid;
   logic              s1_relu;
   logic              s2_valid;
   logic              adv;
   logic              cfg_hit;
   logic              grp_hit;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign cfg_hit  = cfg_we && (32'(cfg_group) < 32'(N_GROUPS)) && (32'(cfg_lane) < 32'(N_LANES));
   assign grp_hit  = 32'(in_group) < 32'(N_GROUPS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int g = 0; g < N_GROUPS; g++)
            for (int l = 0; l < N_LANES; l++)
               bias_q[g][l] <= '0;
      end else if (cfg_hit) begin
         bias_q[cfg_group][cfg_lane] <= cfg_data;
      end
   end

   // Table is read before the edge, so a same-edge write is seen only by later beats.
   always_comb begin
      sel_bias = '0;
      if (grp_hit)
         for (int l = 0; l < N_LANES; l++)
            sel_bias[l*DATA_W +: DATA_W] = bias_q[in_group][l];
   end

   // Overflow shows as disagreement between the carry-out sign and the result sign.
   always_comb begin
      res = '0;
      sum = '0;
      for (int l = 0; l < N_LANES; l++) begin
         sum = {s1_data[l*DATA_W + DATA_W - 1], s1_data[l*DATA_W +: DATA_W]}
             + {s1_bias[l*DATA_W + DATA_W - 1], s1_bias[l*DATA_W +: DATA_W]};
         if (sum[DATA_W] != sum[DATA_W-1])
            res[l*DATA_W +: DATA_W] = {sum[DATA_W], {(DATA_W-1){!sum[DATA_W]}}};
         else
            res[l*DATA_W +: DATA_W] = sum[DATA_W-1:0];
         if (s1_relu && res[l*DATA_W + DATA_W - 1])
            res[l*DATA_W +: DATA_W] = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_relu   <= 1'b0;
         s1_data   <= '0;
         s1_bias   <= '0;
         s2_valid  <= 1'b0;
         s2_data   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_data <= in_data;
            s1_bias <= sel_bias;
            s1_relu <= relu_en;
         end
         s2_valid <= s1_valid;
         if (s1_valid)
            s2_data <= res;
         out_valid <= s2_valid;
         if (s2_valid)
            out_data <= s2_data;
      end
   end
endmodule

// File: tb/tb_bias_bank_adder.sv
// tb/tb_bias_bank_adder.sv - scoreboard bench for bias_bank_adder
// Expected beats are queued at acceptance and popped when the output handshake fires.
module tb_bias_bank_adder;
   localparam int NL   = 16;
   localparam int DW   = 18;
   localparam int NG   = 6;
   localparam int GW   = 3;
   localparam int LW   = 4;
   localparam int W    = NL * DW;
   localparam int MAXV = (1 << (DW - 1)) - 1;
   localparam int MINV = -(1 << (DW - 1));

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_we = 1'b0;
   logic [GW-1:0] cfg_group = '0;
   logic [LW-1:0] cfg_lane = '0;
   logic [DW-1:0] cfg_data = '0;
   logic          relu_en = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [GW-1:0] in_group = '0;
   logic [W-1:0]  in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_data;

   int           n_tests = 0;
   int           n_fail = 0;
   int           bm [8][NL];
   logic [W-1:0] sb [$];

   always #5 clk = ~clk;

   bias_bank_adder #(.N_LANES(NL), .DATA_W(DW), .N_GROUPS(NG)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_group(cfg_group), .cfg_lane(cfg_lane),
      .cfg_data(cfg_data), .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready),
      .in_group(in_group), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data)
   );

   function automatic logic [W-1:0] model(input logic [W-1:0] d, input int g, input bit relu);
      logic [W-1:0] r;
      int s;
      r = '0;
      for (int k = 0; k < NL; k++) begin
         s = int'($signed(d[k*DW +: DW])) + ((g < NG) ? bm[g][k] : 0);
         if (s > MAXV) s = MAXV;
         if (s < MINV) s = MINV;
         if (relu && s < 0) s = 0;
         r[k*DW +: DW] = s[DW-1:0];
      end
      return r;
   endfunction

   function automatic logic [W-1:0] splat(input int v);
      logic [W-1:0] r;
      for (int k = 0; k < NL; k++) r[k*DW +: DW] = v[DW-1:0];
      return r;
   endfunction

   task automatic tick(output bit acc, output bit fire, output logic [W-1:0] got);
      #1;
      acc  = in_valid && in_ready;
      fire = out_valid && out_ready;
      got  = out_data;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic cfg_write(input int g, input int l, input int v);
      bit a, f;
      logic [W-1:0] x;
      cfg_we = 1'b1; cfg_group = g[GW-1:0]; cfg_lane = l[LW-1:0]; cfg_data = v[DW-1:0];
      tick(a, f, x);
      cfg_we = 1'b0;
      if (g < NG) bm[g][l] = v;
   endtask

   task automatic test_reset();
      bit a, f;
      logic [W-1:0] x, e;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk); @(negedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b0 || out_data !== '0) begin
         n_fail++; $display("FAIL reset_state: out_valid=%b out_data=%h required 0 and 0", out_valid, out_data);
      end
      rst_n = 1'b1;
      @(negedge clk); #1;
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
      in_valid = 1'b1; in_group = '0; relu_en = 1'b0; in_data = splat(100);
      e = model(in_data, 0, 1'b0);
      tick(a, f, x);
      in_valid = 1'b0;
      if (a) sb.push_back(e);
      n_tests++;
      if (!a) begin n_fail++; $display("FAIL reset_accept: accepted %b required 1", a); end
      for (int c = 0; c < 3; c++) begin
         #1;
         n_tests++;
         if (out_valid !== (c == 2)) begin
            n_fail++; $display("FAIL latency_edge%0d: out_valid %b required %b", c, out_valid, (c == 2));
         end
         if (c < 2) tick(a, f, x);
      end
      n_tests++;
      if (sb.size() == 0 || out_data !== splat(100)) begin
         n_fail++; $display("FAIL reset_default_data: got %h required %h", out_data, splat(100));
      end
      if (sb.size() != 0) e = sb.pop_front();
      tick(a, f, x);
   endtask

   task automatic test_bank_select();
      bit a, f;
      logic [W-1:0] x, e, ex;
      int g [2];
      int i, cyc, nf, first;
      for (int k = 0; k < NL; k++) begin cfg_write(3, k, 4 * k); cfg_write(5, k, -k); end
      g[0] = 3; g[1] = 5;
      i = 0; cyc = 0; nf = 0; first = 0; out_ready = 1'b1; relu_en = 1'b0;
      while ((i < 2 || sb.size() != 0) && cyc < 40) begin
         in_valid = (i < 2); in_data = splat(1000); in_group = g[i%2][GW-1:0];
         e = model(in_data, g[i%2], 1'b0);
         tick(a, f, x);
         cyc++;
         if (f) begin
            n_tests++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL bank_extra: got %h required none", x); end
            else begin
               ex = sb.pop_front();
               if (x !== ex) begin n_fail++; $display("FAIL bank_data%0d: got %h required %h", nf, x, ex); end
            end
            nf++;
            if (nf == 1) first = cyc;
            else begin
               n_tests++;
               if (cyc != first + 1) begin n_fail++; $display("FAIL bank_back_to_back: cycle %0d required %0d", cyc, first + 1); end
            end
         end
         if (a) begin sb.push_back(e); i++; end
      end
      in_valid = 1'b0;
      n_tests++;
      if (nf != 2) begin n_fail++; $display("FAIL bank_count: got %0d beats required 2", nf); end
   endtask

   task automatic test_saturation();
      bit a, f;
      logic [W-1:0] x, e, ex, d;
      int i, cyc, nf;
      cfg_write(1, 0, 500); cfg_write(1, 1, -500); cfg_write(1, 2, 3);
      for (int k = 0; k < NL; k++) d[k*DW +: DW] = DW'(1000 * k);
      d[0 +: DW] = DW'(131000); d[DW +: DW] = DW'(-131000); d[2*DW +: DW] = DW'(-5);
      i = 0; cyc = 0; nf = 0; out_ready = 1'b1;
      while ((i < 2 || sb.size() != 0) && cyc < 40) begin
         in_valid = (i < 2); in_data = d; in_group = 3'd1; relu_en = (i == 1);
         e = model(in_data, 1, relu_en);
         tick(a, f, x);
         cyc++;
         if (f) begin
            n_tests++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL sat_extra: got %h required none", x); end
            else begin
               ex = sb.pop_front();
               if (x !== ex) begin n_fail++; $display("FAIL sat_data%0d: got %h required %h", nf, x, ex); end
            end
            n_tests++;
            if (nf == 0 && (x[0 +: DW] !== 18'h1ffff || x[DW +: DW] !== 18'h20000 || x[2*DW +: DW] !== 18'h3fffe)) begin
               n_fail++; $display("FAIL sat_lanes: got %h %h %h required 1ffff 20000 3fffe", x[0 +: DW], x[DW +: DW], x[2*DW +: DW]);
            end
            if (nf == 1 && (x[0 +: DW] !== 18'h1ffff || x[DW +: DW] !== 18'h0 || x[2*DW +: DW] !== 18'h0)) begin
               n_fail++; $display("FAIL relu_lanes: got %h %h %h required 1ffff 0 0", x[0 +: DW], x[DW +: DW], x[2*DW +: DW]);
            end
            nf++;
         end
         if (a) begin sb.push_back(e); i++; end
      end
      in_valid = 1'b0; relu_en = 1'b0;
      n_tests++;
      if (nf != 2) begin n_fail++; $display("FAIL sat_count: got %0d beats required 2", nf); end
   endtask

   task automatic test_backpressure();
      bit a, f;
      logic [W-1:0] x, e, ex;
      int i, cyc, nf, nstall;
      for (int k = 0; k < NL; k++) cfg_write(4, k, 7 * k - 20);
      i = 0; cyc = 0; nf = 0; nstall = 0;
      while ((i < 6 || sb.size() != 0) && cyc < 60) begin
         in_valid = (i < 6); in_data = splat(i + 1); in_group = 3'd4; relu_en = 1'b0;
         out_ready = !(cyc >= 4 && cyc < 7);
         e = model(in_data, 4, 1'b0);
         #1;
         n_tests++;
         if (out_valid && !out_ready) begin
            nstall++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b required 0", in_ready); end
         end else if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flow_in_ready: got %b required 1", in_ready);
         end
         tick(a, f, x);
         cyc++;
         if (f) begin
            n_tests++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL bp_extra: got %h required none", x); end
            else begin
               ex = sb.pop_front();
               if (x !== ex) begin n_fail++; $display("FAIL bp_data%0d: got %h required %h", nf, x, ex); end
            end
            nf++;
         end
         if (a) begin sb.push_back(e); i++; end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_tests++;
      if (nf != 6 || nstall != 3) begin
         n_fail++; $display("FAIL bp_count: got %0d beats %0d stalls required 6 beats 3 stalls", nf, nstall);
      end
   endtask

   task automatic test_collision();
      bit a, f;
      logic [W-1:0] x, e, ex;
      int cyc, nf;
      out_ready = 1'b1; relu_en = 1'b0;
      in_valid = 1'b1; in_group = 3'd2; in_data = splat(10);
      cfg_we = 1'b1; cfg_group = 3'd2; cfg_lane = '0; cfg_data = 18'd50;
      e = model(in_data, 2, 1'b0);
      tick(a, f, x);
      cfg_we = 1'b0; bm[2][0] = 50;
      if (a) sb.push_back(e);
      e = model(in_data, 2, 1'b0);
      tick(a, f, x);
      if (a) sb.push_back(e);
      in_valid = 1'b0;
      cyc = 0; nf = 0;
      while (sb.size() != 0 && cyc < 20) begin
         tick(a, f, x);
         cyc++;
         if (f) begin
            n_tests++;
            ex = sb.pop_front();
            if (x !== ex || x[0 +: DW] !== ((nf == 0) ? 18'd10 : 18'd60)) begin
               n_fail++; $display("FAIL collision%0d: got %h required %h", nf, x, ex);
            end
            nf++;
         end
      end
      n_tests++;
      if (nf != 2) begin n_fail++; $display("FAIL collision_count: got %0d beats required 2", nf); end
   endtask

   task automatic test_out_of_range();
      bit a, f;
      logic [W-1:0] x, e, ex;
      logic [W-1:0] d [4];
      int g [4];
      int i, cyc, nf;
      cfg_write(6, 0, 999); cfg_write(7, 3, -77);
      g[0] = 6; g[1] = 7; g[2] = 0; g[3] = 4;
      for (int b = 0; b < 4; b++)
         for (int k = 0; k < NL; k++) d[b][k*DW +: DW] = DW'($urandom_range(200000, 0)) - DW'(100000);
      i = 0; cyc = 0; nf = 0; out_ready = 1'b1; relu_en = 1'b0;
      while ((i < 4 || sb.size() != 0) && cyc < 40) begin
         in_valid = (i < 4); in_data = d[i%4]; in_group = g[i%4][GW-1:0];
         e = model(in_data, g[i%4], 1'b0);
         tick(a, f, x);
         cyc++;
         if (f) begin
            n_tests++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL oor_extra: got %h required none", x); end
            else begin
               ex = sb.pop_front();
               if (x !== ex || (nf < 2 && x !== d[nf])) begin
                  n_fail++; $display("FAIL oor_data%0d: got %h required %h", nf, x, ex);
               end
            end
            nf++;
         end
         if (a) begin sb.push_back(e); i++; end
      end
      in_valid = 1'b0;
      n_tests++;
      if (nf != 4) begin n_fail++; $display("FAIL oor_count: got %0d beats required 4", nf); end
   endtask

   task automatic test_reset_midstream();
      bit a, f;
      logic [W-1:0] x, e, ex;
      int cyc, nf;
      out_ready = 1'b0; relu_en = 1'b0; in_group = 3'd3;
      for (int b = 0; b < 2; b++) begin
         in_valid = 1'b1; in_data = splat(b + 7);
         tick(a, f, x);
      end
      in_valid = 1'b0;
      tick(a, f, x);
      #1;
      n_tests++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midreset_pre: out_valid %b required 1", out_valid); end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || out_data !== '0) begin
         n_fail++; $display("FAIL midreset_drop: out_valid=%b out_data=%h required 0 and 0", out_valid, out_data);
      end
      sb.delete();
      for (int gi = 0; gi < 8; gi++) for (int k = 0; k < NL; k++) bm[gi][k] = 0;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      nf = 0;
      for (int c = 0; c < 8; c++) begin
         tick(a, f, x);
         if (f) nf++;
      end
      n_tests++;
      if (nf != 0) begin n_fail++; $display("FAIL midreset_stale: got %0d beats required 0", nf); end
      in_valid = 1'b1; in_group = 3'd5; in_data = splat(500);
      e = model(in_data, 5, 1'b0);
      tick(a, f, x);
      in_valid = 1'b0;
      if (a) sb.push_back(e);
      cyc = 0; nf = 0;
      while (sb.size() != 0 && cyc < 20) begin
         tick(a, f, x);
         cyc++;
         if (f) begin
            n_tests++;
            ex = sb.pop_front();
            if (x !== ex || x[DW +: DW] !== 18'd500) begin
               n_fail++; $display("FAIL midreset_bias_clear: got %h required %h", x, ex);
            end
            nf++;
         end
      end
      n_tests++;
      if (nf != 1) begin n_fail++; $display("FAIL midreset_count: got %0d beats required 1", nf); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_bank_select();
      test_saturation();
      test_backpressure();
      test_collision();
      test_out_of_range();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/bias_bank_adder.md
Name: bias_bank_adder

Overview:
- Programmable, multi-group successor to the fixed per-layer bias constant blocks.
- Holds N_GROUPS banks of N_LANES signed biases, loaded at run time through a configuration write port.
- Adds the selected bank to a stream of N_LANES adder-tree sums with signed saturation and optional ReLU.
- Sits between the adder tree and the activation/output buffer of each layer, so one instance serves every layer and filter group.

Parameters:
- N_LANES, 16, lanes per beat (adder-tree width).
- DATA_W, 18, signed two's-complement width of sums, biases and results.
- N_GROUPS, 8, number of bias banks.
- GRP_W, $clog2(N_GROUPS), width of group indices.
- LANE_W, $clog2(N_LANES), width of lane index.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  bias write strobe.
- cfg_group  in  GRP_W  bank written.
- cfg_lane  in  LANE_W  lane written.
- cfg_data  in  DATA_W  bias value.
- relu_en  in  1  clamp negative results to 0 for the accepted beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_group  in  GRP_W  bank applied to this beat.
- in_data  in  N_LANES*DATA_W  sums; lane k at [DATA_W*(k+1)-1 : DATA_W*k].
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  N_LANES*DATA_W  biased results, same lane packing.

Behaviour:
- Reset (rst_n low, asynchronous): all bias entries = 0; both pipeline valid bits = 0; out_valid = 0; out_data = 0. in_ready = 1 from the first cycle after reset release.
- Reset mid-stream discards in-flight beats; no partial output appears.
- Config write: on the clk edge with cfg_we = 1, bias[cfg_group][cfg_lane] <= cfg_data. Accepted only if cfg_group < N_GROUPS; otherwise ignored.
- Config/data ordering: writes are independent of the handshake.
  - A beat accepted on the same edge as a write to its bank uses the old value.
  - Beats accepted on later edges use the new value.
- Pipeline: 2 register stages with a global enable: adv = !out_valid || out_ready. in_ready = adv.
  - A beat is accepted when in_valid && in_ready.
  - S1 captures in_data, the selected bank (all lanes, read combinationally from the table) and relu_en.
  - S2 captures the result.
  - Latency: a beat accepted at edge t is presented with out_valid = 1 after edge t+2 when out_ready stays 1.
  - Throughput: 1 beat/cycle.
- Stall: while out_valid && !out_ready, S1, S2, out_data and out_valid hold. No beat is lost or duplicated.
  - Pipeline bubbles (invalid S1) are collapsed only when adv is 1; no skid buffer.
- in_group >= N_GROUPS: bias treated as 0 for all lanes.
- Arithmetic, per lane:
  - sum = sext(data) + sext(bias), DATA_W+1 bits.
  - If sum > 2^(DATA_W-1)-1, result = 2^(DATA_W-1)-1 (131071 at the default).
  - If sum < -2^(DATA_W-1), result = -2^(DATA_W-1) (-131072).
  - Otherwise result = sum truncated to DATA_W bits.
  - If the beat's relu_en = 1 and the result < 0, result = 0. ReLU is applied after saturation.
- Lanes are fully independent; saturation in one lane does not affect the others.
- out_data is registered; no combinational path from in_data to out_data. in_ready depends combinationally on out_ready.

Test Plan:
- Reset default: after reset, beat in_group = 0, all lanes = 100, relu_en = 0 -> out_data all lanes 100, out_valid exactly 2 cycles after acceptance.
- Bank load and select:
  - Load group 3 lane k = k*4 and group 5 lane k = -k.
  - Beats of 1000 with group 3 then group 5 back-to-back -> lane k = 1000+4k, then 1000-k, on consecutive cycles.
- Saturation and ReLU:
  - Lane 0: 131000 + bias 500 -> 131071.
  - Lane 1: -131000 + bias -500 -> -131072.
  - Lane 1 with relu_en = 1 -> 0.
  - Lane 2: -5 + bias 3 with relu_en = 1 -> 0; relu_en = 0 -> -2.
- Backpressure:
  - Stream 6 beats (values 1..6), hold out_ready low for 3 cycles mid-stream -> in_ready low during the stall; outputs 1..6 + bias in order, none dropped or repeated.
- Write/accept collision:
  - Write group 2 lane 0 = 50 on the same edge a group-2 beat (data 10) is accepted -> lane 0 = 10 + old bias.
  - Next beat -> 60.
- Edge cases:
  - Out-of-range: in_group = N_GROUPS (when N_GROUPS is not a power of two, e.g. 6) -> output equals input.
  - cfg write to that group is ignored.
  - Assert rst_n low with 2 beats in flight -> out_valid drops immediately, no stale output after release.
